// File: rtl/adc_rx_pkg.sv
// Shared encodings and constants for the ADC receive capture block.
//   ADC_DW       default ADC data width
//   DF_OFFSET    MSB flip that maps two's complement onto offset binary
//   rx_state_e   receive FSM encoding, reported on RX_STATE
package adc_rx_pkg;

  localparam int unsigned ADC_DW = 12;
  localparam logic [ADC_DW-1:0] DF_OFFSET = 12'h800;

  // ST_RUN covers both SETTLE and STREAM; a separate flag tells them apart
  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_WAIT_CAL = 2'd1,
    ST_CAL      = 2'd2,
    ST_RUN      = 2'd3
  } rx_state_e;

endpackage

// File: rtl/adc_rx_stuck_det.sv
// Flags an ADC whose data bus has not changed for STUCK_LIM consecutive streamed samples.
//   clk_i, rst_n_i  clock, async active-low reset
//   run_i           high while samples are being streamed
//   d_i             registered ADC sample
//   clr_i           clears the sticky flag
//   stuck_o         sticky stuck-data flag
module adc_rx_stuck_det
  import adc_rx_pkg::*;
#(
  parameter int unsigned DW        = ADC_DW,
  parameter int unsigned STUCK_LIM = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          run_i,
  input  logic [DW-1:0] d_i,
  input  logic          clr_i,
  output logic          stuck_o
);

  localparam int unsigned CNT_W = $clog2(STUCK_LIM + 1);

  logic [DW-1:0]    prev_q;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             stuck_q;

  // Length of the current run of identical samples, counting the first one
  always_comb begin
    run_len_d = run_len_q;
    if (!run_i) begin
      run_len_d = '0;
    end else if ((run_len_q != '0) && (d_i == prev_q)) begin
      if (run_len_q != CNT_W'(STUCK_LIM)) run_len_d = run_len_q + CNT_W'(1);
    end else begin
      run_len_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q    <= '0;
      run_len_q <= '0;
      stuck_q   <= 1'b0;
    end else begin
      prev_q    <= d_i;
      run_len_q <= run_len_d;
      if (run_len_d == CNT_W'(STUCK_LIM)) stuck_q <= 1'b1;
      else if (clr_i)                     stuck_q <= 1'b0;
    end
  end

  assign stuck_o = stuck_q;

endmodule

// File: rtl/adc_rx_capture.sv
// Receive side of the 12-bit ADC interface: registers the ADC bus, follows calibration,
// discards the pipeline-latency samples after calibration, converts two's complement to
// offset binary and streams valid-qualified samples; keeps OVF/SEU/config status.
//   CLK, RST_N                      clock, async active-low reset
//   ADC_D/OVF/CAL_BUSY/SEU          ADC outputs
//   ENABLE, DF_TC, CLR_STATS        ADC mode mirror, data-format select, stats clear
//   DOUT, DOUT_VALID, DOUT_OVF      sample stream (2 cycles after ADC_D)
//   RX_STATE, CAL_DONE              FSM state and calibration-done pulse
//   OVF_CNT, SEU_STICKY, CFG_ERR    status
//   STUCK                           stuck-data flag; only built when ADC_RX_STUCK_DET_EN is defined
module adc_rx_capture
  import adc_rx_pkg::*;
#(
  parameter int unsigned DW         = ADC_DW,
  parameter int unsigned SETTLE_CYC = 12,
  parameter int unsigned OVF_CNT_W  = 16,
  parameter int unsigned STUCK_LIM  = 64
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DW-1:0]        ADC_D,
  input  logic                 ADC_OVF,
  input  logic                 ADC_CAL_BUSY,
  input  logic                 ADC_SEU,
  input  logic                 ENABLE,
  input  logic                 DF_TC,
  input  logic                 CLR_STATS,
  output logic [DW-1:0]        DOUT,
  output logic                 DOUT_VALID,
  output logic                 DOUT_OVF,
  output logic [1:0]           RX_STATE,
  output logic                 CAL_DONE,
  output logic [OVF_CNT_W-1:0] OVF_CNT,
  output logic                 SEU_STICKY,
  output logic                 CFG_ERR,
  output logic                 STUCK
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DW-1:0] OFFSET = (DW == ADC_DW) ? DW'(DF_OFFSET) : {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]        d_q;
  logic                 ovf_q, cb_q, seu_q, df_q, df_prev_q;
  rx_state_e            state_q, state_d;
  logic                 settle_q, settle_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cal_done_d, df_chg;
  logic                 streaming;
  logic [DW-1:0]        dout_q;
  logic                 dout_valid_q, dout_ovf_q, cal_done_q;
  logic [OVF_CNT_W-1:0] ovf_cnt_q;
  logic                 seu_sticky_q, cfg_err_q;
  logic                 stuck;

  // Stage 1: capture ADC outputs; df_prev_q lets a DF change be seen
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_q       <= '0;
      ovf_q     <= 1'b0;
      cb_q      <= 1'b0;
      seu_q     <= 1'b0;
      df_q      <= 1'b0;
      df_prev_q <= 1'b0;
    end else begin
      d_q       <= ADC_D;
      ovf_q     <= ADC_OVF;
      cb_q      <= ADC_CAL_BUSY;
      seu_q     <= ADC_SEU;
      df_q      <= DF_TC;
      df_prev_q <= df_q;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_OFF;
      settle_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  // FSM next state: disable beats a DF change, which beats normal sequencing
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    cal_done_d = 1'b0;
    df_chg     = 1'b0;
    if (!ENABLE) begin
      state_d  = ST_OFF;
      settle_d = 1'b0;
      cnt_d    = '0;
    end else if ((state_q != ST_OFF) && (df_q != df_prev_q)) begin
      state_d  = ST_WAIT_CAL;
      settle_d = 1'b0;
      cnt_d    = '0;
      df_chg   = 1'b1;
    end else begin
      case (state_q)
        ST_OFF:      state_d = ST_WAIT_CAL;
        ST_WAIT_CAL: if (cb_q) state_d = ST_CAL;
        ST_CAL: begin
          if (!cb_q) begin
            state_d    = ST_RUN;
            settle_d   = 1'b1;
            cnt_d      = CNT_W'(SETTLE_CYC - 1);
            cal_done_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (cb_q) begin
            state_d  = ST_CAL;
            settle_d = 1'b0;
            cnt_d    = '0;
          end else if (settle_q) begin
            if (cnt_q == '0) settle_d = 1'b0;
            else             cnt_d    = cnt_q - CNT_W'(1);
          end
        end
        default:     state_d = ST_OFF;
      endcase
    end
  end

  assign streaming = (state_q == ST_RUN) && !settle_q;

  // Stage 2 outputs and status
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
      cal_done_q   <= 1'b0;
      ovf_cnt_q    <= '0;
      seu_sticky_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      dout_q       <= streaming ? (df_q ? (d_q ^ OFFSET) : d_q) : '0;
      dout_valid_q <= streaming;
      dout_ovf_q   <= streaming & ovf_q;
      cal_done_q   <= cal_done_d;
      if (CLR_STATS)                              ovf_cnt_q <= '0;
      else if (streaming && ovf_q && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
      if (seu_q)          seu_sticky_q <= 1'b1;
      else if (CLR_STATS) seu_sticky_q <= 1'b0;
      if (df_chg)         cfg_err_q <= 1'b1;
      else if (CLR_STATS) cfg_err_q <= 1'b0;
    end
  end

`ifdef ADC_RX_STUCK_DET_EN
  adc_rx_stuck_det #(
    .DW        (DW),
    .STUCK_LIM (STUCK_LIM)
  ) u_stuck_det (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .run_i   (streaming),
    .d_i     (d_q),
    .clr_i   (CLR_STATS),
    .stuck_o (stuck)
  );
`else
  // STUCK_LIM only matters when detection is built in
  assign stuck = (STUCK_LIM == 0) && 1'b0;
`endif

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT_OVF   = dout_ovf_q;
  assign RX_STATE   = state_q;
  assign CAL_DONE   = cal_done_q;
  assign OVF_CNT    = ovf_cnt_q;
  assign SEU_STICKY = seu_sticky_q;
  assign CFG_ERR    = cfg_err_q;
  assign STUCK      = stuck;

endmodule

// File: tb/tb_adc_rx_capture.sv
// Directed self-checking bench for adc_rx_capture (default parameters).
module tb_adc_rx_capture;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [11:0] ADC_D;
  logic        ADC_OVF, ADC_CAL_BUSY, ADC_SEU, ENABLE, DF_TC, CLR_STATS;
  logic [11:0] DOUT;
  logic        DOUT_VALID, DOUT_OVF, CAL_DONE, SEU_STICKY, CFG_ERR, STUCK;
  logic [1:0]  RX_STATE;
  logic [15:0] OVF_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  adc_rx_capture dut (
    .CLK(CLK), .RST_N(RST_N), .ADC_D(ADC_D), .ADC_OVF(ADC_OVF),
    .ADC_CAL_BUSY(ADC_CAL_BUSY), .ADC_SEU(ADC_SEU), .ENABLE(ENABLE), .DF_TC(DF_TC),
    .CLR_STATS(CLR_STATS), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_OVF(DOUT_OVF),
    .RX_STATE(RX_STATE), .CAL_DONE(CAL_DONE), .OVF_CNT(OVF_CNT), .SEU_STICKY(SEU_STICKY),
    .CFG_ERR(CFG_ERR), .STUCK(STUCK)
  );

  always #5 CLK = ~CLK;

  // Watches the outputs after CAL_BUSY drops; bounded, -1 means never seen
  task automatic watch_settle(output int done_at, output int valid_at, output int pulses);
    done_at = -1; valid_at = -1; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (CAL_DONE === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
      if (DOUT_VALID === 1'b1 && valid_at < 0) valid_at = i;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; ADC_D = '0; ADC_OVF = 0; ADC_CAL_BUSY = 0; ADC_SEU = 0;
    ENABLE = 0; DF_TC = 1'b1; CLR_STATS = 0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({DOUT, DOUT_VALID, DOUT_OVF, RX_STATE, CAL_DONE, OVF_CNT, SEU_STICKY, CFG_ERR, STUCK} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs, required all 0 (RX_STATE=%0d DOUT=%h)", RX_STATE, DOUT);
    end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd0 || CFG_ERR !== 1'b0) begin
      n_bad++; $display("FAIL off_df_ignored: RX_STATE=%0d CFG_ERR=%b, required 0/0", RX_STATE, CFG_ERR);
    end
  endtask

  task automatic test_cal_entry;
    int d, v, p;
    ENABLE = 1'b1; ADC_CAL_BUSY = 1'b1; ADC_D = 12'h3C3;
    repeat (1000) @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd2 || DOUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL cal_state: RX_STATE=%0d valid=%b, required 2/0", RX_STATE, DOUT_VALID);
    end
    ADC_CAL_BUSY = 1'b0;
    watch_settle(d, v, p);
    n_cmp++;
    if (p !== 1 || d !== 2) begin
      n_bad++; $display("FAIL cal_done_pulse: pulses=%0d at=%0d, required 1 at 2", p, d);
    end
    n_cmp++;
    if (v - d !== 13) begin
      n_bad++; $display("FAIL settle_len: valid_at-done_at=%0d, required 13 (12 invalid cycles)", v - d);
    end
    n_cmp++;
    if (RX_STATE !== 2'd3 || CFG_ERR !== 1'b0) begin
      n_bad++; $display("FAIL stream_state: RX_STATE=%0d CFG_ERR=%b, required 3/0", RX_STATE, CFG_ERR);
    end
  endtask

  task automatic test_df_decode;
    logic [11:0] din [4];
    logic [11:0] exp [4];
    din[0] = 12'h000; din[1] = 12'h7FF; din[2] = 12'h123; din[3] = 12'hFFF;
    exp[0] = 12'h800; exp[1] = 12'hFFF; exp[2] = 12'h923; exp[3] = 12'h7FF;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) ADC_D = din[i];
      @(negedge CLK);
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (DOUT !== exp[i-1] || DOUT_VALID !== 1'b1) begin
          n_bad++; $display("FAIL df_decode[%0d]: DOUT=%h valid=%b, required %h/1", i - 1, DOUT, DOUT_VALID, exp[i-1]);
        end
      end
    end
  endtask

  task automatic test_ovf;
    for (int i = 0; i < 8; i++) begin
      ADC_OVF = (i < 5);
      @(negedge CLK);
      if (i >= 1) begin
        n_cmp++;
        if (DOUT_OVF !== ((i - 1) < 5)) begin
          n_bad++; $display("FAIL dout_ovf[%0d]: got %b, required %b", i, DOUT_OVF, ((i - 1) < 5));
        end
      end
    end
    n_cmp++;
    if (OVF_CNT !== 16'd5) begin
      n_bad++; $display("FAIL ovf_cnt: got %0d, required 5", OVF_CNT);
    end
    ADC_OVF = 1'b1; CLR_STATS = 1'b1;
    @(negedge CLK); ADC_OVF = 1'b0;
    @(negedge CLK); CLR_STATS = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (OVF_CNT !== 16'd0) begin
      n_bad++; $display("FAIL ovf_clr_wins: got %0d, required 0", OVF_CNT);
    end
  endtask

  task automatic test_seu;
    ADC_SEU = 1'b1; @(negedge CLK); ADC_SEU = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (SEU_STICKY !== 1'b1) begin n_bad++; $display("FAIL seu_set: got %b, required 1", SEU_STICKY); end
    CLR_STATS = 1'b1; @(negedge CLK); CLR_STATS = 1'b0;
    n_cmp++;
    if (SEU_STICKY !== 1'b0) begin n_bad++; $display("FAIL seu_clr: got %b, required 0", SEU_STICKY); end
    ADC_SEU = 1'b1; CLR_STATS = 1'b1;
    @(negedge CLK); ADC_SEU = 1'b0;
    @(negedge CLK); CLR_STATS = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (SEU_STICKY !== 1'b1) begin n_bad++; $display("FAIL seu_set_wins: got %b, required 1", SEU_STICKY); end
    CLR_STATS = 1'b1; @(negedge CLK); CLR_STATS = 1'b0;
  endtask

  task automatic test_recal;
    int d, v, p;
    ADC_D = 12'h5A5;
    repeat (2) @(negedge CLK);
    ADC_CAL_BUSY = 1'b1;
    @(negedge CLK); @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd2 || DOUT_VALID !== 1'b1 || DOUT !== 12'hDA5) begin
      n_bad++; $display("FAIL recal_enter: RX_STATE=%0d valid=%b DOUT=%h, required 2/1/DA5", RX_STATE, DOUT_VALID, DOUT);
    end
    @(negedge CLK);
    n_cmp++;
    if (DOUT_VALID !== 1'b0 || DOUT !== 12'h000) begin
      n_bad++; $display("FAIL recal_drop: valid=%b DOUT=%h, required 0/000", DOUT_VALID, DOUT);
    end
    repeat (10) @(negedge CLK);
    ADC_CAL_BUSY = 1'b0;
    watch_settle(d, v, p);
    n_cmp++;
    if (p !== 1 || v - d !== 13) begin
      n_bad++; $display("FAIL recal_settle: pulses=%0d gap=%0d, required 1/13", p, v - d);
    end
  endtask

  task automatic test_cfg_err_disable;
    DF_TC = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd3 || CFG_ERR !== 1'b0) begin
      n_bad++; $display("FAIL df_pipe: RX_STATE=%0d CFG_ERR=%b, required 3/0", RX_STATE, CFG_ERR);
    end
    @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd1 || CFG_ERR !== 1'b1) begin
      n_bad++; $display("FAIL df_toggle: RX_STATE=%0d CFG_ERR=%b, required 1/1", RX_STATE, CFG_ERR);
    end
    CLR_STATS = 1'b1; @(negedge CLK); CLR_STATS = 1'b0;
    n_cmp++;
    if (CFG_ERR !== 1'b0) begin n_bad++; $display("FAIL cfg_err_clr: got %b, required 0", CFG_ERR); end
    ENABLE = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (RX_STATE !== 2'd0 || DOUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL disable: RX_STATE=%0d valid=%b, required 0/0", RX_STATE, DOUT_VALID);
    end
  endtask

  task automatic test_stuck;
    int d, v, p;
    logic exp_stuck;
`ifdef ADC_RX_STUCK_DET_EN
    exp_stuck = 1'b1;
`else
    exp_stuck = 1'b0;
`endif
    ENABLE = 1'b1; ADC_CAL_BUSY = 1'b1;
    repeat (5) @(negedge CLK);
    ADC_CAL_BUSY = 1'b0;
    watch_settle(d, v, p);
    n_cmp++;
    if (v < 0) begin n_bad++; $display("FAIL restream: valid never seen, required within 40 cycles"); end
    for (int i = 0; i < 4; i++) begin ADC_D = 12'(i); @(negedge CLK); end
    ADC_D = 12'h123;
    repeat (40) @(negedge CLK);
    n_cmp++;
    if (STUCK !== 1'b0 || DOUT !== 12'h123) begin
      n_bad++; $display("FAIL stuck_early: STUCK=%b DOUT=%h, required 0/123", STUCK, DOUT);
    end
    repeat (30) @(negedge CLK);
    n_cmp++;
    if (STUCK !== exp_stuck) begin n_bad++; $display("FAIL stuck_flag: got %b, required %b", STUCK, exp_stuck); end
  endtask

  task automatic test_async_reset;
    ADC_SEU = 1'b1; @(negedge CLK); ADC_SEU = 1'b0;
    ADC_OVF = 1'b1; @(negedge CLK); ADC_OVF = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (SEU_STICKY !== 1'b1 || OVF_CNT !== 16'd1 || DOUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: SEU=%b OVF_CNT=%0d valid=%b, required 1/1/1", SEU_STICKY, OVF_CNT, DOUT_VALID);
    end
    #3 RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({DOUT, DOUT_VALID, DOUT_OVF, RX_STATE, CAL_DONE, OVF_CNT, SEU_STICKY, CFG_ERR, STUCK} !== '0) begin
      n_bad++; $display("FAIL async_reset: RX_STATE=%0d valid=%b OVF_CNT=%0d SEU=%b STUCK=%b, required all 0",
                        RX_STATE, DOUT_VALID, OVF_CNT, SEU_STICKY, STUCK);
    end
    @(negedge CLK); RST_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cal_entry();
    test_df_decode();
    test_ovf();
    test_seu();
    test_recal();
    test_cfg_err_disable();
    test_stuck();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
